// File: rtl/duart_rx_fifo.sv
// Receive holding FIFO for one DUART channel (RHR stack, default depth 3).
// Optional build macro DUART_RX_FFULL_IRQ_EN adds i_FFULL_Sel to steer the interrupt to FFULL.
module duart_rx_fifo #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_Clock,
  input  logic             i_Rst,
  input  logic             i_RX_DV,
  input  logic [7:0]       i_RX_Byte,
  input  logic             i_RX_En,
  input  logic             i_Rd,
  input  logic             i_Flush,
  input  logic             i_Reset_Err,
`ifdef DUART_RX_FFULL_IRQ_EN
  input  logic             i_FFULL_Sel,
`endif
  output logic [7:0]       o_RX_Data,
  output logic             o_RxRDY,
  output logic             o_FFULL,
  output logic             o_Overrun,
  output logic [CNT_W-1:0] o_Count,
  output logic             o_RX_Int
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overrun;

  logic push;
  logic pop;
  logic is_full;
  logic not_empty;
  logic accept;
  logic overrun_set;

  // A full FIFO still takes a byte if the CPU frees a slot in the same cycle.
  always_comb begin
    not_empty   = (count != '0);
    is_full     = (count == FULL_CNT);
    push        = i_RX_DV & i_RX_En;
    pop         = i_Rd & not_empty;
    accept      = push & (~is_full | pop);
    overrun_set = push & is_full & ~pop & ~i_Flush;
  end

  // Pointers and occupancy; flush wins over any push/pop in the same cycle.
  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (accept && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !accept) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Storage is deliberately not reset; the count gates what is visible.
  always_ff @(posedge i_Clock) begin
    if (accept && !i_Flush) begin
      mem[wr_ptr] <= i_RX_Byte;
    end
  end

  // Sticky overrun; a new overrun in the clearing cycle keeps the flag set.
  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      overrun <= 1'b0;
    end else if (overrun_set) begin
      overrun <= 1'b1;
    end else if (i_Reset_Err) begin
      overrun <= 1'b0;
    end
  end

  always_comb begin
    o_RX_Data = not_empty ? mem[rd_ptr] : 8'h00;
    o_RxRDY   = not_empty;
    o_FFULL   = is_full;
    o_Count   = count;
    o_Overrun = overrun;
`ifdef DUART_RX_FFULL_IRQ_EN
    o_RX_Int  = i_FFULL_Sel ? is_full : not_empty;
`else
    o_RX_Int  = not_empty;
`endif
  end

endmodule

// File: tb/tb_duart_rx_fifo.sv
// Directed self-checking bench for duart_rx_fifo (default depth 3).
module tb_duart_rx_fifo;

  logic       clk;
  logic       rst;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rx_en;
  logic       rd;
  logic       flush;
  logic       reset_err;
  logic       ffull_sel;
  logic [7:0] rx_data;
  logic       rxrdy;
  logic       ffull;
  logic       overrun;
  logic [1:0] count;
  logic       rx_int;

  int checks   = 0;
  int failures = 0;

  duart_rx_fifo dut (
    .i_Clock     (clk),
    .i_Rst       (rst),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte),
    .i_RX_En     (rx_en),
    .i_Rd        (rd),
    .i_Flush     (flush),
    .i_Reset_Err (reset_err),
`ifdef DUART_RX_FFULL_IRQ_EN
    .i_FFULL_Sel (ffull_sel),
`endif
    .o_RX_Data   (rx_data),
    .o_RxRDY     (rxrdy),
    .o_FFULL     (ffull),
    .o_Overrun   (overrun),
    .o_Count     (count),
    .o_RX_Int    (rx_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it and inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_dv = 1'b1; rx_byte = b;
    step();
    rx_dv = 1'b0;
  endtask

  task automatic read_one();
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  task automatic check_int(input string tag, input logic exp_rdy_path);
`ifdef DUART_RX_FFULL_IRQ_EN
    check_eq(tag, 32'(rx_int), 32'(ffull_sel ? ffull : exp_rdy_path));
`else
    check_eq(tag, 32'(rx_int), 32'(exp_rdy_path));
`endif
  endtask

  initial begin
    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; rx_en = 1'b1; rd = 1'b0;
    flush = 1'b0; reset_err = 1'b0; ffull_sel = 1'b0;
    step(); step();
    check_eq("rst_rdy",   32'(rxrdy),   32'd0);
    check_eq("rst_full",  32'(ffull),   32'd0);
    check_eq("rst_data",  32'(rx_data), 32'h00);
    check_eq("rst_count", 32'(count),   32'd0);
    check_eq("rst_ovr",   32'(overrun), 32'd0);
    check_eq("rst_int",   32'(rx_int),  32'd0);
    rst = 1'b0;
    step();

    // Single byte round trip
    push_byte(8'hA5);
    check_eq("t1_rdy",   32'(rxrdy),   32'd1);
    check_eq("t1_data",  32'(rx_data), 32'hA5);
    check_eq("t1_count", 32'(count),   32'd1);
    check_int("t1_int", 1'b1);
    read_one();
    check_eq("t1_rd_rdy",  32'(rxrdy),   32'd0);
    check_eq("t1_rd_data", 32'(rx_data), 32'h00);
    check_int("t1_rd_int", 1'b0);

    // Fill, overrun, drain
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    check_eq("t2_full",  32'(ffull),   32'd1);
    check_eq("t2_count", 32'(count),   32'd3);
    check_eq("t2_ovr0",  32'(overrun), 32'd0);
    push_byte(8'h44);
    check_eq("t2_ovr1",  32'(overrun), 32'd1);
    check_eq("t2_cnt_ovr", 32'(count), 32'd3);
    check_eq("t2_head",  32'(rx_data), 32'h11);
    read_one();
    check_eq("t2_rd2",   32'(rx_data), 32'h22);
    read_one();
    check_eq("t2_rd3",   32'(rx_data), 32'h33);
    read_one();
    check_eq("t2_empty_cnt",  32'(count),   32'd0);
    check_eq("t2_empty_data", 32'(rx_data), 32'h00);
    read_one();
    check_eq("t2_rd_empty_cnt", 32'(count), 32'd0);
    // Set and clear together: set wins
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    rx_dv = 1'b1; rx_byte = 8'h04; reset_err = 1'b1;
    step();
    rx_dv = 1'b0; reset_err = 1'b0;
    check_eq("t2_set_wins", 32'(overrun), 32'd1);
    reset_err = 1'b1;
    step();
    reset_err = 1'b0;
    check_eq("t2_clr", 32'(overrun), 32'd0);
    read_one(); read_one(); read_one();
    check_eq("t2_drain", 32'(count), 32'd0);

    // Push and read in the same cycle on a full FIFO
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    rx_dv = 1'b1; rx_byte = 8'h55; rd = 1'b1;
    step();
    rx_dv = 1'b0; rd = 1'b0;
    check_eq("t3_ovr",   32'(overrun), 32'd0);
    check_eq("t3_count", 32'(count),   32'd3);
    check_eq("t3_head",  32'(rx_data), 32'h22);
    read_one();
    check_eq("t3_rd33", 32'(rx_data), 32'h33);
    read_one();
    check_eq("t3_rd55", 32'(rx_data), 32'h55);
    read_one();
    check_eq("t3_empty", 32'(count), 32'd0);

    // Receiver disabled, then flush with a coincident push
    rx_en = 1'b0;
    push_byte(8'h77);
    check_eq("t4_dis_cnt", 32'(count), 32'd0);
    check_eq("t4_dis_rdy", 32'(rxrdy), 32'd0);
    rx_en = 1'b1;
    push_byte(8'h61); push_byte(8'h62); push_byte(8'h63); push_byte(8'h64);
    read_one();
    check_eq("t4_pre_cnt", 32'(count),   32'd2);
    check_eq("t4_pre_ovr", 32'(overrun), 32'd1);
    check_eq("t4_pre_head", 32'(rx_data), 32'h62);
    rx_dv = 1'b1; rx_byte = 8'h88; flush = 1'b1;
    step();
    rx_dv = 1'b0; flush = 1'b0;
    check_eq("t4_fl_cnt",  32'(count),   32'd0);
    check_eq("t4_fl_rdy",  32'(rxrdy),   32'd0);
    check_eq("t4_fl_data", 32'(rx_data), 32'h00);
    check_eq("t4_fl_ovr",  32'(overrun), 32'd1);
    push_byte(8'h9C);
    check_eq("t4_post_data", 32'(rx_data), 32'h9C);
    check_eq("t4_post_cnt",  32'(count),   32'd1);

    // Interrupt steering across counts (FFULL select only in the macro build)
    ffull_sel = 1'b1;
    #1;
    check_int("t6_int_c1", 1'b1);
    push_byte(8'hB1);
    check_int("t6_int_c2", 1'b1);
    push_byte(8'hB2);
    check_int("t6_int_c3", 1'b1);
    ffull_sel = 1'b0;

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_rdy",   32'(rxrdy),   32'd0);
    check_eq("t5_full",  32'(ffull),   32'd0);
    check_eq("t5_count", 32'(count),   32'd0);
    check_eq("t5_data",  32'(rx_data), 32'h00);
    check_eq("t5_ovr",   32'(overrun), 32'd0);
    check_eq("t5_int",   32'(rx_int),  32'd0);
    step();
    rst = 1'b0;
    step();
    push_byte(8'hC3);
    check_eq("t5_after", 32'(rx_data), 32'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
